apb3_bridge_mux: RTL



---
 rtl/apb3_pkg.sv | 21 ++
 rtl/apb3_timeout_timer.sv | 40 ++++
 rtl/apb3_bridge_mux.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/apb3_pkg.sv
// Shared types and elaboration helpers for the APB3 bridge/decoder.
// The bridge FSM encoding is exported so checkers can bind to it.
package apb3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb3_bridge_state_e;

    // Width of the port-select field; a single port still needs one bit of storage.
    function automatic int apb3_sel_width(input int num_master);
        return (num_master > 1) ? $clog2(num_master) : 1;
    endfunction

    function automatic int apb3_cnt_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/apb3_timeout_timer.sv
// ACCESS-phase wait counter; expired flags the last permitted wait cycle.
// With TIMEOUT_CYCLES = 0 the timer is absent and never expires.
import apb3_pkg::*;

module apb3_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = apb3_cnt_width(TIMEOUT_CYCLES);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_timer_inputs;
            assign unused_timer_inputs = ^{clk, rst, clear, enable};
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign expired = enable && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb3_bridge_mux.sv
// Registered APB3 1-to-N bridge: decodes one upstream master onto NUM_MASTER
// slave ports, completing unmapped or hung accesses upstream with PSLVERR.
import apb3_pkg::*;

module apb3_bridge_mux #(
    parameter int                SLAVE_APB_AW   = 20,
    parameter int                MASTER_APB_AW  = 10,
    parameter int                APB_DW         = 32,
    parameter int                NUM_MASTER     = 10,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [APB_DW-1:0] ERR_DATA       = APB_DW'(32'hDEAD_BEEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SLAVE_APB_AW-1:0]  s_apb3_paddr,
    input  logic                     s_apb3_psel,
    input  logic                     s_apb3_penable,
    input  logic                     s_apb3_pwrite,
    input  logic [APB_DW-1:0]        s_apb3_pwdata,
    output logic                     s_apb3_pready,
    output logic [APB_DW-1:0]        s_apb3_prdata,
    output logic                     s_apb3_pslverror,
    output logic [MASTER_APB_AW-1:0] m_apb3_paddr     [NUM_MASTER],
    output logic                     m_apb3_psel      [NUM_MASTER],
    output logic                     m_apb3_penable   [NUM_MASTER],
    output logic                     m_apb3_pwrite    [NUM_MASTER],
    output logic [APB_DW-1:0]        m_apb3_pwdata    [NUM_MASTER],
    input  logic                     m_apb3_pready    [NUM_MASTER],
    input  logic [APB_DW-1:0]        m_apb3_prdata    [NUM_MASTER],
    input  logic                     m_apb3_pslverror [NUM_MASTER],
    output logic                     decerr_evt,
    output logic                     timeout_evt,
    output logic [1:0]               dbg_state
);

    localparam int                 SEL_WID      = apb3_sel_width(NUM_MASTER);
    localparam logic [SEL_WID:0]   NUM_MASTER_W = (SEL_WID + 1)'(NUM_MASTER);

    // Handshake: upstream request is taken in IDLE whenever psel is high; the
    // upstream ACCESS phase is held until the single-cycle pready from RESP.
    // Downstream transfers are SETUP (psel) then ACCESS (psel+penable) until
    // pready is sampled in ACCESS or the timer aborts the transfer.
    generate
        if (SEL_WID + MASTER_APB_AW > SLAVE_APB_AW) begin : g_bad_widths
            $error("apb3_bridge_mux: select field plus port window exceed upstream address width");
        end
    endgenerate

    apb3_bridge_state_e        state;
    logic [SEL_WID-1:0]        tgt_q;
    logic [MASTER_APB_AW-1:0]  addr_q;
    logic                      write_q;
    logic [APB_DW-1:0]         wdata_q;
    logic [NUM_MASTER-1:0]     psel_q;
    logic [NUM_MASTER-1:0]     penable_q;
    logic                      s_pready_q;
    logic [APB_DW-1:0]         s_prdata_q;
    logic                      s_pslverr_q;
    logic                      decerr_q;
    logic                      timeout_q;

    logic [SEL_WID-1:0]        req_tgt;
    logic                      req_mapped;
    logic                      sel_pready;
    logic [APB_DW-1:0]         sel_prdata;
    logic                      sel_pslverr;
    logic                      expired;
    logic                      unused_upstream;

    assign req_tgt         = s_apb3_paddr[MASTER_APB_AW +: SEL_WID];
    assign req_mapped      = ({1'b0, req_tgt} < NUM_MASTER_W);
    assign unused_upstream = ^{s_apb3_paddr, s_apb3_penable};

    function automatic logic [NUM_MASTER-1:0] port_onehot(input logic [SEL_WID-1:0] t);
        logic [NUM_MASTER-1:0] r;
        for (int i = 0; i < NUM_MASTER; i++) begin
            r[i] = (t == SEL_WID'(i));
        end
        return r;
    endfunction

    // Writes never return data; any errored read returns the poison pattern.
    function automatic logic [APB_DW-1:0] resp_data(input logic wr, input logic err,
                                                    input logic [APB_DW-1:0] d);
        if (wr) begin
            return '0;
        end
        return err ? ERR_DATA : d;
    endfunction

    always_comb begin
        sel_pready  = 1'b0;
        sel_prdata  = '0;
        sel_pslverr = 1'b0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (tgt_q == SEL_WID'(i)) begin
                sel_pready  = m_apb3_pready[i];
                sel_prdata  = m_apb3_prdata[i];
                sel_pslverr = m_apb3_pslverror[i];
            end
        end
    end

    apb3_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == SETUP),
        .enable  (state == ACCESS),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tgt_q       <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            psel_q      <= '0;
            penable_q   <= '0;
            s_pready_q  <= 1'b0;
            s_prdata_q  <= '0;
            s_pslverr_q <= 1'b0;
            decerr_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            s_pready_q <= 1'b0;
            decerr_q   <= 1'b0;
            timeout_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_apb3_psel) begin
                        tgt_q   <= req_tgt;
                        addr_q  <= s_apb3_paddr[MASTER_APB_AW-1:0];
                        write_q <= s_apb3_pwrite;
                        wdata_q <= s_apb3_pwdata;
                        if (req_mapped) begin
                            state  <= SETUP;
                            psel_q <= port_onehot(req_tgt);
                        end else begin
                            state       <= RESP;
                            s_pready_q  <= 1'b1;
                            s_pslverr_q <= 1'b1;
                            s_prdata_q  <= resp_data(s_apb3_pwrite, 1'b1, '0);
                            decerr_q    <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_q <= psel_q;
                end
                ACCESS: begin
                    // A ready slave wins over a timer expiring in the same cycle.
                    if (sel_pready) begin
                        state       <= RESP;
                        psel_q      <= '0;
                        penable_q   <= '0;
                        s_pready_q  <= 1'b1;
                        s_pslverr_q <= sel_pslverr;
                        s_prdata_q  <= resp_data(write_q, sel_pslverr, sel_prdata);
                    end else if (expired) begin
                        state       <= RESP;
                        psel_q      <= '0;
                        penable_q   <= '0;
                        s_pready_q  <= 1'b1;
                        s_pslverr_q <= 1'b1;
                        s_prdata_q  <= resp_data(write_q, 1'b1, '0);
                        timeout_q   <= 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    s_pslverr_q <= 1'b0;
                    s_prdata_q  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_MASTER; g++) begin : g_port
            assign m_apb3_paddr[g]   = addr_q;
            assign m_apb3_psel[g]    = psel_q[g];
            assign m_apb3_penable[g] = penable_q[g];
            assign m_apb3_pwrite[g]  = write_q;
            assign m_apb3_pwdata[g]  = wdata_q;
        end
    endgenerate

    assign s_apb3_pready    = s_pready_q;
    assign s_apb3_prdata    = s_prdata_q;
    assign s_apb3_pslverror = s_pslverr_q;
    assign decerr_evt       = decerr_q;
    assign timeout_evt      = timeout_q;
    assign dbg_state        = state;

endmodule
